// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache for the fetch stage.
// A hit returns instrF combinationally in the same cycle. A miss raises
// icache_stall and refills the whole line from a word-wide memory, one
// word per mem_ready beat. The line is then re-looked-up with the current pcF.
// Ports:
//   clk, reset     - clock; synchronous active-low reset
//   pcF            - fetch byte address (bits [1:0] ignored)
//   instrF         - instruction at pcF, valid while icache_stall==0
//   icache_stall   - high while instrF is not valid
//   mem_req        - high for every cycle of a line fill
//   mem_addr       - byte address of the word being fetched (registered)
//   mem_rdata      - fill data, taken when mem_req && mem_ready
//   mem_ready      - memory beat strobe
module icache_dm #(
  parameter int unsigned NLINES         = 16,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pcF,
  output logic [31:0] instrF,
  output logic        icache_stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int unsigned OB = $clog2(WORDS_PER_LINE);
  localparam int unsigned IB = $clog2(NLINES);
  localparam int unsigned TB = 32 - OB - IB - 2;

  typedef enum logic {IDLE, FILL} state_t;

  state_t            state;
  state_t            state_next;
  logic [NLINES-1:0] valid;
  logic [TB-1:0]     tags [NLINES];
  logic [31:0]       data [NLINES*WORDS_PER_LINE];
  logic [TB-1:0]     fill_tag;
  logic [IB-1:0]     fill_index;
  logic [OB-1:0]     count;

  logic [OB-1:0]     offset;
  logic [IB-1:0]     index;
  logic [TB-1:0]     tag;
  logic              hit;
  logic              beat;
  logic              last_beat;
  logic              unused_bits;

  // Address split of the fetch address.
  assign offset      = pcF[OB+1:2];
  assign index       = pcF[OB+IB+1:OB+2];
  assign tag         = pcF[31:OB+IB+2];
  assign unused_bits = ^pcF[1:0];

  assign hit       = valid[index] && (tags[index] == tag);
  assign beat      = (state == FILL) && mem_ready;
  assign last_beat = beat && (count == OB'(WORDS_PER_LINE - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next state and outputs; reset forces all outputs quiet.
  always_comb begin
    state_next   = state;
    instrF       = '0;
    icache_stall = 1'b0;
    mem_req      = 1'b0;
    case (state)
      IDLE: begin
        if (hit) begin
          instrF = data[{index, offset}];
        end else begin
          icache_stall = 1'b1;
          state_next   = FILL;
        end
      end
      FILL: begin
        mem_req      = 1'b1;
        icache_stall = 1'b1;
        if (last_beat) state_next = IDLE;
      end
    endcase
    if (!reset) begin
      instrF       = '0;
      icache_stall = 1'b0;
      mem_req      = 1'b0;
      state_next   = IDLE;
    end
  end

  // Fill bookkeeping: latch the target line on a miss, advance per beat.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid      <= '0;
      count      <= '0;
      mem_addr   <= '0;
      fill_tag   <= '0;
      fill_index <= '0;
    end else if (state == IDLE && !hit) begin
      fill_tag     <= tag;
      fill_index   <= index;
      valid[index] <= 1'b0;
      count        <= '0;
      mem_addr     <= {tag, index, {OB{1'b0}}, 2'b00};
    end else if (beat) begin
      if (last_beat) begin
        valid[fill_index] <= 1'b1;
        count             <= '0;
      end else begin
        count    <= count + OB'(1);
        mem_addr <= {fill_tag, fill_index, count + OB'(1), 2'b00};
      end
    end
  end

  // Data and tag arrays (not reset; validity is tracked separately).
  always_ff @(posedge clk) begin
    if (reset && beat) begin
      data[{fill_index, count}] <= mem_rdata;
      if (last_beat) tags[fill_index] <= fill_tag;
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: directed scenarios plus random fetches,
// checked against a line-level model of a direct-mapped cache.
module tb_icache_dm;

  localparam int unsigned NL  = 16;
  localparam int unsigned WPL = 4;
  localparam int unsigned OB  = $clog2(WPL);
  localparam int unsigned IB  = $clog2(NL);

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pcF;
  logic [31:0] instrF;
  logic        icache_stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int n_tests = 0;
  int n_fail  = 0;

  bit          mvalid [NL];
  int unsigned mtag   [NL];
  bit          ready_q[$];
  bit          rand_ready = 1'b0;

  icache_dm #(.NLINES(NL), .WORDS_PER_LINE(WPL)) dut (
    .clk(clk), .reset(reset), .pcF(pcF), .instrF(instrF),
    .icache_stall(icache_stall), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // Backing memory contents, indexed by word-aligned byte address.
  function automatic logic [31:0] memfn(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h2008_0005;
      32'h4:   return 32'h2009_000C;
      32'h8:   return 32'h0109_5020;
      32'hC:   return 32'hAC0A_0054;
      default: return a * 32'h9E37_79B1 + 32'h0123_4567;
    endcase
  endfunction

  assign mem_rdata = memfn(mem_addr);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int unsigned idx_of(input logic [31:0] a);
    return 32'(a >> (OB + 2)) % NL;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] a);
    return 32'(a >> (OB + IB + 2));
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return mvalid[idx_of(a)] && (mtag[idx_of(a)] == tag_of(a));
  endfunction

  function automatic void model_clear();
    foreach (mvalid[i]) mvalid[i] = 1'b0;
  endfunction

  function automatic bit next_ready();
    if (ready_q.size() != 0) return ready_q.pop_front();
    if (rand_ready) return ($urandom_range(0, 2) != 0);
    return 1'b1;
  endfunction

  // One fetch of pc: either a single-cycle hit, or miss + fill followed by a
  // re-lookup. With chg set, pcF switches to alt during the fill.
  task automatic access(input logic [31:0] pc, input bit chg, input logic [31:0] alt);
    logic [31:0] cur;
    logic [31:0] base;
    bit          do_chg;
    bit          hit_seen;
    bit          r;
    int          k;
    int          guard;
    int          idle;
    int          stall_cyc;
    cur      = pc;
    do_chg   = chg;
    hit_seen = 1'b0;
    pcF      = pc;
    for (int pass = 0; pass < 3; pass++) begin
      mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (model_hit(cur)) begin
        check("hit_stall", 32'(icache_stall), 32'd0);
        check("hit_req", 32'(mem_req), 32'd0);
        check("hit_data", instrF, memfn(cur & ~32'h3));
        @(posedge clk); #1;
        mem_ready = 1'b0;
        hit_seen  = 1'b1;
        break;
      end
      stall_cyc = int'(icache_stall);
      check("miss_stall", 32'(icache_stall), 32'd1);
      check("miss_instr", instrF, 32'd0);
      check("miss_req", 32'(mem_req), 32'd0);
      base = cur & ~32'(WPL * 4 - 1);
      @(posedge clk); #1;
      if (do_chg) pcF = alt;
      k = 0; guard = 0; idle = 0;
      while (k < int'(WPL) && guard < 100) begin
        r = next_ready();
        mem_ready = r;
        @(negedge clk);
        if (icache_stall) stall_cyc++;
        check("fill_req", 32'(mem_req), 32'd1);
        check("fill_stall", 32'(icache_stall), 32'd1);
        check("fill_instr", instrF, 32'd0);
        check("fill_addr", mem_addr, base + 32'(4 * k));
        @(posedge clk); #1;
        if (r) k++;
        else   idle++;
        guard++;
      end
      check("fill_done", 32'(k), 32'(WPL));
      check("stall_cycles", 32'(stall_cyc), 32'(1 + WPL + idle));
      mem_ready = 1'b0;
      mvalid[idx_of(cur)] = 1'b1;
      mtag[idx_of(cur)]   = tag_of(cur);
      if (do_chg) cur = alt;
      do_chg = 1'b0;
    end
    check("access_hit_seen", 32'(hit_seen), 32'd1);
  endtask

  initial begin
    reset     = 1'b0;
    pcF       = 32'h1234_5678;
    mem_ready = 1'b1;
    model_clear();
    // Outputs must be quiet while reset is held.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_stall", 32'(icache_stall), 32'd0);
      check("rst_req", 32'(mem_req), 32'd0);
      check("rst_instr", instrF, 32'd0);
    end
    check("rst_addr", mem_addr, 32'd0);
    @(posedge clk); #1;
    reset     = 1'b1;
    mem_ready = 1'b0;

    // Cold miss, then sequential hits in the same line.
    access(32'h0, 1'b0, 32'h0);
    access(32'h4, 1'b0, 32'h0);
    access(32'h8, 1'b0, 32'h0);
    access(32'hC, 1'b0, 32'h0);

    // Conflict miss evicts line 0, so 0x0 misses again.
    access(32'h100, 1'b0, 32'h0);
    access(32'h0, 1'b0, 32'h0);

    // Wait states during a fill.
    ready_q = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    access(32'h40, 1'b0, 32'h0);
    access(32'h44, 1'b0, 32'h0);

    // Reset after two beats of a fill aborts it.
    pcF       = 32'h80;
    mem_ready = 1'b1;
    @(negedge clk);
    check("mid_miss_stall", 32'(icache_stall), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_req", 32'(mem_req), 32'd0);
    check("mid_rst_stall", 32'(icache_stall), 32'd0);
    @(posedge clk); #1;
    reset     = 1'b1;
    mem_ready = 1'b0;
    model_clear();
    access(32'h80, 1'b0, 32'h0);
    access(32'h0, 1'b0, 32'h0);

    // pcF moves during a fill: fill completes, then a new miss at 0x200.
    access(32'h20, 1'b1, 32'h200);
    access(32'h24, 1'b0, 32'h0);

    // Random fetches over a small address pool to mix hits and conflicts.
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, NL - 1)) << 4) |
          (32'($urandom_range(0, WPL - 1)) << 2) | 32'($urandom_range(0, 3));
      b = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, NL - 1)) << 4) |
          (32'($urandom_range(0, WPL - 1)) << 2);
      access(a, ($urandom_range(0, 7) == 0), b);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache between the pipelined datapath's fetch stage (pcF in, instrF out) and a slow word-wide instruction memory.
- A hit returns the instruction combinationally in the same cycle.
- A miss raises icache_stall, which is ORed into stallF/stallD by the integration logic. The block then fills the whole line from memory one word per mem_ready beat, and resumes.

Parameters:
- NLINES, 16, number of cache lines; power of two, at least 2.
- WORDS_PER_LINE, 4, 32-bit words per line; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (reset==0 resets on the next rising edge of clk).
- pcF  in  32  fetch address; bits [1:0] ignored.
- instrF  out  32  instruction at pcF; valid when icache_stall==0.
- icache_stall  out  1  1 = instrF not valid; pipeline must hold pcF.
- mem_req  out  1  fill request; high for every cycle of a fill.
- mem_addr  out  32  word address of the requested fill word (byte address, [1:0]=00).
- mem_rdata  in  32  fill data; sampled when mem_req && mem_ready.
- mem_ready  in  1  memory beat strobe; one word per high cycle.

Behaviour:
- Address split, with OB=log2(WORDS_PER_LINE) and IB=log2(NLINES):
  - offset = pcF[OB+1:2]
  - index = pcF[OB+IB+1:OB+2]
  - tag = pcF[31:OB+IB+2]
  - Defaults: offset [3:2], index [7:4], tag [31:8] (24 bits).
- Storage per line: valid bit, tag, and WORDS_PER_LINE data words. Data and tags are not reset; valid bits are.
- Reset (reset==0 at a clock edge):
  - all valid bits cleared; FSM to IDLE; fill counter 0; mem_addr 0.
  - While reset==0: mem_req=0, icache_stall=0, instrF=0.
- FSM states: IDLE, FILL.
- IDLE:
  - hit = valid[index] && tag match.
  - Hit: instrF = data[index][offset], icache_stall=0, mem_req=0.
  - Miss: icache_stall=1 combinationally in the same cycle, instrF=0 (NOP). On the next edge:
    - latch fill tag and index from pcF;
    - clear valid[index];
    - counter=0;
    - go to FILL.
- FILL:
  - mem_req=1, icache_stall=1, instrF=0.
  - mem_addr = {fill_tag, fill_index, counter, 2'b00}; registered and stable until the beat completes.
  - Each cycle with mem_ready==1: write mem_rdata into data[fill_index][counter], counter++.
  - Beat with counter==WORDS_PER_LINE-1: write tag, set valid[fill_index], go to IDLE. The next cycle re-looks up pcF.
  - mem_ready==0: hold state, counter and address.
- Timing:
  - Miss penalty with zero-wait memory: icache_stall high for WORDS_PER_LINE+1 cycles (miss-detect cycle plus one per beat).
  - Each idle mem_ready cycle adds one cycle.
- Boundary conditions:
  - mem_ready in IDLE is ignored; no array write.
  - pcF changing during FILL does not affect the fill address; the fill always completes. The IDLE lookup afterwards uses the then-current pcF, which may miss again.
  - Conflict miss replaces the line at that index unconditionally.
  - Counter wraps only via the FILL->IDLE transition; never exceeds WORDS_PER_LINE-1.
  - reset==0 during FILL aborts the fill: IDLE, all valid cleared, mem_req=0 from that edge. A partially written line stays invalid.
  - No writes or invalidation from the datapath; no self-modifying-code support.

Test Plan:
- Cold miss, default parameters, pcF=0x00000000, mem_ready=1 every cycle, memory returns 0x20080005, 0x2009000C, 0x01095020, 0xAC0A0054 for mem_addr 0x0, 0x4, 0x8, 0xC:
  - icache_stall high exactly 5 cycles;
  - mem_addr sequence 0x0, 0x4, 0x8, 0xC;
  - then instrF=0x20080005 with stall=0.
- After the cold miss, pcF=0x4, 0x8, 0xC on consecutive cycles:
  - stall=0 each cycle, mem_req=0;
  - instrF=0x2009000C, 0x01095020, 0xAC0A0054.
- Conflict: pcF=0x100 (index 0, tag 1):
  - miss; fill addresses 0x100 to 0x10C;
  - then pcF=0x0 misses again (line evicted).
- Wait states: miss at pcF=0x40 with mem_ready pattern 0,1,0,0,1,1,0,1:
  - stall high 9 cycles;
  - mem_addr holds 0x40 until the first beat, then 0x44, 0x48, 0x4C;
  - line index 4 valid afterwards.
- Reset mid-fill: reset=0 after 2 beats of a miss at 0x80, then reset=1 with pcF=0x80:
  - mem_req=0 and stall=0 during reset;
  - a fresh miss follows with mem_addr restarting at 0x80.
- pcF changed to 0x200 during the fill of 0x20:
  - fill completes for 0x20–0x2C;
  - then a new miss with fill at 0x200.
